// File: rtl/SerialTOFEDDefs.sv
// Shared types for the serial 3-of-5 check lane scheduler.
package SerialTOFEDDefs;

  typedef enum logic {FALSE = 1'b0, TRUE = 1'b1} bool_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2,
    ST_GAP    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/tofed_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module tofed_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                            req,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr,
  input  logic                                       en,
  output logic [NREQ-1:0]                            grant,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gid,
  output logic                                       any
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] idx;

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (en && req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gid        = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tofed_rr_scheduler.sv
// Round-robin sharing of one serial 3-of-5 check lane among NREQ word producers.
// state     | meaning
// ST_IDLE   | waiting for a request; grant and latch word on any req_valid
// ST_SHIFT  | driving word MSB-first on ser_din, counting ones
// ST_REPORT | one-cycle result strobe
// ST_GAP    | idle spacing before the next grant
module tofed_rr_scheduler
  import SerialTOFEDDefs::*;
#(
  parameter int NREQ        = 4,
  parameter int WORD_W      = 5,
  parameter int ONES_TARGET = 3,
  parameter int GAP         = 1
) (
  input  logic                                       clk,
  input  logic                                       resetH,
  input  logic [NREQ-1:0]                            req_valid,
  input  logic [NREQ*WORD_W-1:0]                     req_word,
  output logic [NREQ-1:0]                            req_ready,
  output logic                                       ser_din,
  output logic                                       ser_active,
  output logic                                       ser_first,
  output logic                                       res_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] res_id,
  output logic [WORD_W-1:0]                          res_word,
  output bool_t                                      res_is_tofed,
  output logic                                       busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int OW  = $clog2(WORD_W + 1);
  localparam logic [1:0] GAP_LOAD = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  sched_state_t      state_q;
  logic [WORD_W-1:0] word_q;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    ptr_q;
  logic [BW-1:0]     bit_idx_q;
  logic [OW-1:0]     ones_q;
  logic [OW-1:0]     ones_d;
  logic [1:0]        gap_q;
  logic [IDW-1:0]    res_id_q;
  logic [WORD_W-1:0] res_word_q;
  bool_t             res_tofed_q;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gid;
  logic              any;
  logic              arb_en;
  logic [WORD_W-1:0] gnt_word;

  // Reset masks the grant so req_ready stays low while resetH is high.
  assign arb_en = (state_q == ST_IDLE) && !resetH;

  tofed_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .gid   (gid),
    .any   (any)
  );

  assign gnt_word     = req_word[int'(gid)*WORD_W +: WORD_W];
  assign req_ready    = grant;
  assign ser_active   = (state_q == ST_SHIFT);
  assign ser_din      = ser_active & word_q[bit_idx_q];
  assign ser_first    = ser_active && (bit_idx_q == BW'(WORD_W - 1));
  assign res_valid    = (state_q == ST_REPORT);
  assign busy         = (state_q != ST_IDLE);
  assign res_id       = res_id_q;
  assign res_word     = res_word_q;
  assign res_is_tofed = res_tofed_q;
  assign ones_d       = ones_q + OW'(ser_din);

  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      word_q      <= '0;
      id_q        <= '0;
      bit_idx_q   <= '0;
      ones_q      <= '0;
      gap_q       <= '0;
      res_id_q    <= '0;
      res_word_q  <= '0;
      res_tofed_q <= FALSE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            word_q    <= gnt_word;
            id_q      <= gid;
            ones_q    <= '0;
            bit_idx_q <= BW'(WORD_W - 1);
            ptr_q     <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          ones_q <= ones_d;
          // Result fields are captured on the last bit so they are valid during REPORT.
          if (bit_idx_q == '0) begin
            res_id_q    <= id_q;
            res_word_q  <= word_q;
            res_tofed_q <= (ones_d == OW'(ONES_TARGET)) ? TRUE : FALSE;
            state_q     <= ST_REPORT;
          end else begin
            bit_idx_q <= bit_idx_q - 1'b1;
          end
        end
        ST_REPORT: begin
          if (GAP > 0) begin
            gap_q   <= GAP_LOAD;
            state_q <= ST_GAP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_q <= ST_IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
